// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: one shared frame counter, per-channel
// pulse widths that change only at frame boundaries, optionally slew-limited.
module servo_pwm_multi #(
  parameter int NCH        = 4,
  parameter int PERIOD_CYC = 480000,
  parameter int MIN_PULSE  = 12000,
  parameter int MAX_PULSE  = 60000,
  parameter int NPRE       = 3,
  parameter int SLEW       = 0,
  localparam int CW  = $clog2(PERIOD_CYC),
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int PW  = (NPRE > 1) ? $clog2(NPRE) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_flag,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [CW-1:0]  wr_pulse,
  output logic [NCH-1:0] pwm,
  output logic           frame_start,
  output logic           busy,
  output logic [PW-1:0]  preset_idx
);

  logic [CW-1:0]  cnt;
  logic [CW-1:0]  target [NCH];
  logic [CW-1:0]  cur [NCH];
  logic [CW-1:0]  preset_tbl [NPRE];
  logic [PW-1:0]  pre_nxt;
  logic [NCH-1:0] pwm_nxt;
  logic           busy_nxt;
  logic           frame_end;

  function automatic logic [CW-1:0] sat_pulse(input logic [CW-1:0] p);
    if (p < CW'(MIN_PULSE))      return CW'(MIN_PULSE);
    else if (p > CW'(MAX_PULSE)) return CW'(MAX_PULSE);
    else                         return p;
  endfunction

  // Difference is taken one bit wider and signed so a falling target cannot wrap.
  function automatic logic [CW-1:0] slew_step(input logic [CW-1:0] c, input logic [CW-1:0] t);
    logic signed [CW:0] diff;
    logic signed [CW:0] lim;
    diff = $signed({1'b0, t}) - $signed({1'b0, c});
    lim  = (CW+1)'(SLEW);
    if (SLEW == 0 || (diff <= lim && diff >= -lim)) return t;
    else if (diff > 0)                              return c + CW'(SLEW);
    else                                            return c - CW'(SLEW);
  endfunction

  // Preset widths are elaboration constants; the last one lands exactly on MAX_PULSE.
  for (genvar k = 0; k < NPRE; k++) begin : g_preset
    if (k == NPRE - 1) begin : g_last
      assign preset_tbl[k] = CW'(MAX_PULSE);
    end else begin : g_mid
      assign preset_tbl[k] =
        CW'(MIN_PULSE + (longint'(k) * (MAX_PULSE - MIN_PULSE)) / (NPRE - 1));
    end
  end

  assign pre_nxt   = (preset_idx == PW'(NPRE - 1)) ? '0 : preset_idx + 1'b1;
  assign frame_end = (cnt == CW'(PERIOD_CYC - 1));

  always_comb begin
    pwm_nxt  = '0;
    busy_nxt = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      pwm_nxt[i] = (cnt < cur[i]);
      if (cur[i] != target[i]) busy_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      preset_idx  <= '0;
      pwm         <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        target[i] <= CW'(MIN_PULSE);
        cur[i]    <= CW'(MIN_PULSE);
      end
    end else begin
      cnt         <= frame_end ? '0 : cnt + 1'b1;
      pwm         <= pwm_nxt;
      frame_start <= (cnt == '0);
      busy        <= busy_nxt;
      if (key_flag) preset_idx <= pre_nxt;
      // Key first, then the write, so a colliding write wins on its channel.
      for (int i = 0; i < NCH; i++) begin
        if (key_flag)                     target[i] <= preset_tbl[pre_nxt];
        if (wr_en && int'(wr_ch) == i)    target[i] <= sat_pulse(wr_pulse);
        if (frame_end)                    cur[i]    <= slew_step(cur[i], target[i]);
      end
    end
  end

endmodule
